// File: rtl/sub_serial8_bout_if.sv
// Handshake bundle for the byte-serial subtractor: operands and borrow-in
// travel with VALID_IN/READY_IN, difference and borrow-out with
// VALID_OUT/READY_OUT. The master is the producer/consumer side, the slave
// is the subtractor itself.
interface sub_serial8_bout_if #(
  parameter int N = 4
);
  logic [8*N-1:0] I0;
  logic [8*N-1:0] I1;
  logic           BIN;
  logic           VALID_IN;
  logic           READY_IN;
  logic [8*N-1:0] O;
  logic           BOUT;
  logic           VALID_OUT;
  logic           READY_OUT;

  modport master (
    output I0, I1, BIN, VALID_IN, READY_OUT,
    input  READY_IN, O, BOUT, VALID_OUT
  );

  modport slave (
    input  I0, I1, BIN, VALID_IN, READY_OUT,
    output READY_IN, O, BOUT, VALID_OUT
  );
endinterface

// File: rtl/sub_serial8_bout.sv
// Byte-serial subtractor: one 8-bit carry-chain slice computes
// I0 - I1 - BIN over N clocks, LSB byte first, as I0 + ~I1 + ~BIN with the
// inter-byte carry kept in a flop. The carry is the inverted borrow, so the
// final borrow-out is the complement of the last carry.
module sub_serial8_bout #(
  parameter int N = 4
) (
  input logic              CLK,
  input logic              RESET,
  sub_serial8_bout_if.slave bus
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              c_q, c_d;
  logic [N-1:0][7:0] a_q, a_d;
  logic [N-1:0][7:0] b_q, b_d;
  logic [N-1:0][7:0] o_q, o_d;
  logic              bout_q, bout_d;
  logic              ready_in_q, ready_in_d;
  logic              valid_out_q, valid_out_d;

  logic [7:0]        a_byte;
  logic [7:0]        b_byte;
  logic [8:0]        slice_sum;

  // The single carry-chain slice working on the byte selected by the index.
  always_comb begin
    a_byte    = a_q[idx_q];
    b_byte    = b_q[idx_q];
    slice_sum = {1'b0, a_byte} + {1'b0, ~b_byte} + {8'd0, c_q};
  end

  // Next-state and datapath update; handshake flags are precomputed from the
  // next state so READY_IN and VALID_OUT come straight from flops.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    c_d      = c_q;
    a_d      = a_q;
    b_d      = b_q;
    o_d      = o_q;
    bout_d   = bout_q;

    case (state_q)
      IDLE: begin
        if (bus.VALID_IN && ready_in_q) begin
          a_d     = bus.I0;
          b_d     = bus.I1;
          c_d     = ~bus.BIN;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        o_d[idx_q] = slice_sum[7:0];
        c_d        = slice_sum[8];
        if (idx_q == IW'(N - 1)) begin
          bout_d  = ~slice_sum[8];
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        if (bus.READY_OUT) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_in_d  = (state_d == IDLE);
    valid_out_d = (state_d == DONE);
  end

  // State register; reset wins over any handshake and drops an in-flight op.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      c_q         <= 1'b1;
      a_q         <= '0;
      b_q         <= '0;
      o_q         <= '0;
      bout_q      <= 1'b0;
      ready_in_q  <= 1'b1;
      valid_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      c_q         <= c_d;
      a_q         <= a_d;
      b_q         <= b_d;
      o_q         <= o_d;
      bout_q      <= bout_d;
      ready_in_q  <= ready_in_d;
      valid_out_q <= valid_out_d;
    end
  end

  assign bus.READY_IN  = ready_in_q;
  assign bus.VALID_OUT = valid_out_q;
  assign bus.O         = o_q;
  assign bus.BOUT      = bout_q;

endmodule

// File: tb/tb_sub_serial8_bout.sv
// Bench for sub_serial8_bout: directed table on an N=4 instance covering
// reset, borrow ripple, backpressure, input isolation and reset mid-flight,
// then randomized traffic with stalls on N=1, 4 and 16 instances checked
// against plain wide-integer subtraction.
module tb_sub_serial8_bout;

  localparam int N_RAND   = 600;
  localparam int RAND_CYC = 40000;

  typedef struct {
    logic [31:0] i0;
    logic [31:0] i1;
    logic        bin;
    logic [31:0] exp_o;
    logic        exp_b;
    int          hold;
  } vec_t;

  logic clk;
  logic reset;
  logic rand_go;
  int   rand_done = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  sub_serial8_bout_if #(.N(4)) tb_bus ();

  sub_serial8_bout #(.N(4)) dut (
    .CLK   (clk),
    .RESET (reset),
    .bus   (tb_bus)
  );

  // Free-running clock, 10 ns period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [135:0] act, input logic [135:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic scramble_inputs();
    tb_bus.I0  = $urandom;
    tb_bus.I1  = $urandom;
    tb_bus.BIN = 1'($urandom);
  endtask

  task automatic check_reset_vals(input string tag);
    check_output({tag, "_ready_in"}, 136'(tb_bus.READY_IN), 136'(1));
    check_output({tag, "_valid_out"}, 136'(tb_bus.VALID_OUT), 136'(0));
    check_output({tag, "_o"}, 136'(tb_bus.O), 136'(0));
    check_output({tag, "_bout"}, 136'(tb_bus.BOUT), 136'(0));
  endtask

  // One-cycle reset with a competing request present; reset must win.
  task automatic do_reset();
    reset           = 1'b1;
    tb_bus.VALID_IN = 1'b1;
    tb_bus.READY_OUT = 1'b1;
    scramble_inputs();
    @(posedge clk);
    @(negedge clk);
    reset           = 1'b0;
    tb_bus.VALID_IN = 1'b0;
  endtask

  // Starts at a negedge with the block idle, ends at the negedge after accept.
  task automatic apply_stimulus(input logic [31:0] i0, input logic [31:0] i1, input logic bin);
    tb_bus.I0       = i0;
    tb_bus.I1       = i1;
    tb_bus.BIN      = bin;
    tb_bus.VALID_IN = 1'b1;
    check_output("accept_ready_in", 136'(tb_bus.READY_IN), 136'(1));
    @(posedge clk);
    @(negedge clk);
    tb_bus.VALID_IN = 1'b0;
    scramble_inputs();
    check_output("busy_ready_in", 136'(tb_bus.READY_IN), 136'(0));
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!tb_bus.VALID_OUT && lat < 60) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      scramble_inputs();
    end
  endtask

  task automatic run_op(input vec_t v);
    int lat;
    tb_bus.READY_OUT = (v.hold == 0);
    apply_stimulus(v.i0, v.i1, v.bin);
    wait_valid(lat);
    check_output("latency", 136'(lat), 136'(4));
    check_output("result_o", 136'(tb_bus.O), 136'(v.exp_o));
    check_output("result_bout", 136'(tb_bus.BOUT), 136'(v.exp_b));
    for (int h = 0; h < v.hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      scramble_inputs();
      check_output("hold_stable", {tb_bus.VALID_OUT, tb_bus.READY_IN, tb_bus.BOUT, tb_bus.O},
                   {1'b1, 1'b0, v.exp_b, v.exp_o});
    end
    tb_bus.READY_OUT = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_output("post_valid_out", 136'(tb_bus.VALID_OUT), 136'(0));
    check_output("post_ready_in", 136'(tb_bus.READY_IN), 136'(1));
  endtask

  // Directed sequence on the N=4 instance, then release the random agents.
  initial begin
    vec_t vecs[7];
    vec_t after_rst;
    int   lat;

    vecs[0] = '{32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 0};
    vecs[1] = '{32'h1234_5678, 32'h0234_5679, 1'b0, 32'h0FFF_FFFF, 1'b0, 0};
    vecs[2] = '{32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b1, 32'hFFFF_FFFF, 1'b1, 0};
    vecs[3] = '{32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, 32'h0000_0000, 1'b0, 10};
    vecs[4] = '{32'h0000_0100, 32'h0000_0001, 1'b0, 32'h0000_00FF, 1'b0, 0};
    vecs[5] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'hFFFF_FFFE, 1'b0, 0};
    vecs[6] = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 1'b1, 0};
    after_rst = '{32'h0000_0100, 32'h0000_0001, 1'b0, 32'h0000_00FF, 1'b0, 0};

    rand_go          = 1'b0;
    reset            = 1'b1;
    tb_bus.I0        = '0;
    tb_bus.I1        = '0;
    tb_bus.BIN       = 1'b0;
    tb_bus.VALID_IN  = 1'b0;
    tb_bus.READY_OUT = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      check_reset_vals("idle");
      @(posedge clk);
      @(negedge clk);
    end

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i]);
    end

    $display("[TB] reset during RUN at byte 2");
    tb_bus.READY_OUT = 1'b1;
    apply_stimulus(32'h1234_5678, 32'h0000_0001, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    do_reset();
    check_reset_vals("rst_run");
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_output("rst_run_no_stale", 136'(tb_bus.VALID_OUT), 136'(0));
    end
    run_op(after_rst);

    $display("[TB] reset during DONE with result pending");
    tb_bus.READY_OUT = 1'b0;
    apply_stimulus(32'h0000_0005, 32'h0000_0007, 1'b0);
    wait_valid(lat);
    check_output("pend_valid", 136'(tb_bus.VALID_OUT), 136'(1));
    do_reset();
    check_reset_vals("rst_done");
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_output("rst_done_no_stale", 136'(tb_bus.VALID_OUT), 136'(0));
    end
    run_op(after_rst);

    $display("[TB] random regression");
    rand_go = 1'b1;
    for (int c = 0; c < RAND_CYC + 100 && rand_done < 3; c++) begin
      @(posedge clk);
    end
    check_output("rand_all_done", 136'(rand_done), 136'(3));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Randomized traffic per operand width against exact wide subtraction.
  for (genvar gi = 0; gi < 3; gi++) begin : g_rand
    localparam int NB = (gi == 0) ? 1 : ((gi == 1) ? 4 : 16);
    localparam int W  = 8 * NB;

    sub_serial8_bout_if #(.N(NB)) rbus ();

    sub_serial8_bout #(.N(NB)) rdut (
      .CLK   (clk),
      .RESET (reset),
      .bus   (rbus)
    );

    initial begin : drv
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         bi;
      logic [W:0]   full;
      logic [W-1:0] exp_o_q[$];
      logic         exp_b_q[$];
      logic         acc;
      logic         con;
      int           ops;
      int           cyc;

      rbus.I0        = '0;
      rbus.I1        = '0;
      rbus.BIN       = 1'b0;
      rbus.VALID_IN  = 1'b0;
      rbus.READY_OUT = 1'b0;
      wait (rand_go);
      @(negedge clk);
      ops = 0;
      cyc = 0;
      while (ops < N_RAND && cyc < RAND_CYC) begin
        for (int k = 0; k < NB; k++) begin
          a[k*8 +: 8] = 8'($urandom);
          b[k*8 +: 8] = 8'($urandom);
        end
        case ($urandom_range(0, 7))
          0: b = a;
          1: b = '0;
          2: a = '0;
          3: a = '1;
          default: ;
        endcase
        bi = 1'($urandom);
        rbus.I0        = a;
        rbus.I1        = b;
        rbus.BIN       = bi;
        rbus.VALID_IN  = ($urandom_range(0, 3) != 0);
        rbus.READY_OUT = ($urandom_range(0, 3) != 0);
        acc = rbus.VALID_IN & rbus.READY_IN;
        con = rbus.VALID_OUT & rbus.READY_OUT;
        if (con) begin
          check_output($sformatf("n%0d_pending_count", NB), 136'(exp_o_q.size()), 136'(1));
          if (exp_o_q.size() > 0) begin
            check_output($sformatf("n%0d_o", NB), 136'(rbus.O), 136'(exp_o_q[0]));
            check_output($sformatf("n%0d_bout", NB), 136'(rbus.BOUT), 136'(exp_b_q[0]));
            void'(exp_o_q.pop_front());
            void'(exp_b_q.pop_front());
          end
          ops++;
        end
        if (acc) begin
          full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
          exp_o_q.push_back(full[W-1:0]);
          exp_b_q.push_back(full[W]);
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
      end
      rbus.VALID_IN = 1'b0;
      check_output($sformatf("n%0d_ops_done", NB), 136'(ops), 136'(N_RAND));
      rand_done++;
    end
  end

endmodule
